// File: rtl/smp_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// Operand width is fixed here so the job struct and the ports agree.
package smp_pkg;

  localparam int OPW         = 4;
  localparam int PW          = 2 * OPW;
  localparam int TIMEOUT_DEF = 15;
  localparam int CNTW        = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic           id;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } job_t;

endpackage

// File: rtl/smp_rr_arb.sv
// Two-way round-robin grant; the pointer moves to the other requester
// whenever a grant is accepted.
module smp_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_rr;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_rr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr <= 1'b0;
    end else if (i_accept && (o_grant != 2'b00)) begin
      r_rr <= ~o_grant[1];
    end
  end

endmodule

// File: rtl/smp_arbiter.sv
// Shares one multiplier core between two requesters: arbitrate, issue,
// watchdog the core, and hold the tagged result until it is consumed.
module smp_arbiter
  import smp_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            sys_clk,
  input  logic            nsys_rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  output logic            mul_start,
  output logic [OPW-1:0]  mul_a,
  output logic [OPW-1:0]  mul_b,
  input  logic            mul_done,
  input  logic [PW-1:0]   mul_product,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [PW-1:0]   rsp_product,
  output logic            rsp_err,
  output logic [7:0]      jobs_done
);

  localparam logic [CNTW-1:0] TO_LIM = CNTW'(TIMEOUT);

  state_t          r_state, r_state_next;
  job_t            r_job, r_job_next;
  logic [CNTW-1:0] r_cnt, r_cnt_next;
  logic            r_start, r_start_next;
  logic            r_rsp_valid, r_rsp_valid_next;
  logic            r_rsp_id, r_rsp_id_next;
  logic [PW-1:0]   r_rsp_product, r_rsp_product_next;
  logic            r_rsp_err, r_rsp_err_next;
  logic [7:0]      r_jobs_done, r_jobs_done_next;

  logic [1:0]      w_grant;
  logic            w_accept;
  job_t            w_job_in;

  assign w_accept = (r_state == IDLE) && (req_valid != 2'b00);

  smp_rr_arb u_rr_arb (
    .i_clk    (sys_clk),
    .i_rst_n  (nsys_rst),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Grant is one-hot, so bit 1 alone selects the requester.
  always_comb begin
    w_job_in.id = w_grant[1];
    w_job_in.a  = w_grant[1] ? req1_a : req0_a;
    w_job_in.b  = w_grant[1] ? req1_b : req0_b;
  end

  assign req_ready = (r_state == IDLE) ? w_grant : 2'b00;

  always_comb begin
    r_state_next       = r_state;
    r_job_next         = r_job;
    r_cnt_next         = r_cnt;
    r_start_next       = 1'b0;
    r_rsp_valid_next   = r_rsp_valid;
    r_rsp_id_next      = r_rsp_id;
    r_rsp_product_next = r_rsp_product;
    r_rsp_err_next     = r_rsp_err;
    r_jobs_done_next   = r_jobs_done;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          r_job_next   = w_job_in;
          r_start_next = 1'b1;
          r_state_next = ISSUE;
        end
      end
      ISSUE: begin
        r_cnt_next   = '0;
        r_state_next = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          r_rsp_product_next = mul_product;
          r_rsp_err_next     = 1'b0;
          r_rsp_id_next      = r_job.id;
          r_rsp_valid_next   = 1'b1;
          r_state_next       = RESP;
        end else if (r_cnt == TO_LIM) begin
          r_rsp_product_next = '0;
          r_rsp_err_next     = 1'b1;
          r_rsp_id_next      = r_job.id;
          r_rsp_valid_next   = 1'b1;
          r_state_next       = RESP;
        end else begin
          r_cnt_next = r_cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          r_rsp_valid_next = 1'b0;
          r_jobs_done_next = r_jobs_done + 8'd1;
          r_state_next     = IDLE;
        end
      end
      default: r_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge nsys_rst) begin
    if (!nsys_rst) begin
      r_state       <= IDLE;
      r_job         <= '0;
      r_cnt         <= '0;
      r_start       <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_jobs_done   <= '0;
    end else begin
      r_state       <= r_state_next;
      r_job         <= r_job_next;
      r_cnt         <= r_cnt_next;
      r_start       <= r_start_next;
      r_rsp_valid   <= r_rsp_valid_next;
      r_rsp_id      <= r_rsp_id_next;
      r_rsp_product <= r_rsp_product_next;
      r_rsp_err     <= r_rsp_err_next;
      r_jobs_done   <= r_jobs_done_next;
    end
  end

  assign mul_start   = r_start;
  assign mul_a       = r_job.a;
  assign mul_b       = r_job.b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;
  assign rsp_err     = r_rsp_err;
  assign jobs_done   = r_jobs_done;

endmodule

// File: tb/tb_smp_arbiter.sv
// Self-checking bench for smp_arbiter: fixed job table, hand sequences for
// stray done / reset mid-job, then random jobs against a round-robin model.
module tb_smp_arbiter;

  localparam int TO = 15;

  logic       sys_clk;
  logic       nsys_rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       mul_start;
  logic [3:0] mul_a, mul_b;
  logic       mul_done;
  logic [7:0] mul_product;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_product;
  logic       rsp_err;
  logic [7:0] jobs_done;

  int         total;
  int         bad;
  logic [7:0] exp_jobs;
  logic       rr_m;

  smp_arbiter #(.TIMEOUT(TO)) dut (
    .sys_clk     (sys_clk),
    .nsys_rst    (nsys_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .jobs_done   (jobs_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0] v;
    logic [3:0] a0, b0, a1, b1;
    int         lat;
    int         hold;
    bit         idone;
    logic [1:0] gnt;
    logic [7:0] prod;
    logic       err;
  } vec_t;

  vec_t tbl[9];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_mul_start"}, int'(mul_start), 0);
    chk({tag, "_mul_a"}, int'(mul_a), 0);
    chk({tag, "_mul_b"}, int'(mul_b), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_product"}, int'(rsp_product), 0);
    chk({tag, "_rsp_err"}, int'(rsp_err), 0);
    chk({tag, "_jobs_done"}, int'(jobs_done), 0);
  endtask

  // Runs one job from IDLE to the response handshake. lat=0 means the
  // core never answers; otherwise done arrives in the lat-th WAIT cycle.
  task automatic do_job(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1, input int lat,
                        input int hold, input bit idone, input logic [1:0] exp_gnt,
                        input logic [7:0] exp_prod, input logic exp_err);
    logic [3:0] ea, eb;
    int n;
    ea = exp_gnt[1] ? a1 : a0;
    eb = exp_gnt[1] ? b1 : b0;
    req_valid = v; req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    #1;
    chk("req_ready_grant", int'(req_ready), int'(exp_gnt));
    step();
    req_valid = 2'b11;
    chk("issue_mul_start", int'(mul_start), 1);
    chk("issue_req_ready", int'(req_ready), 0);
    chk("issue_mul_a", int'(mul_a), int'(ea));
    chk("issue_mul_b", int'(mul_b), int'(eb));
    if (idone) begin
      mul_product = 8'hEE;
      mul_done = 1'b1;
    end
    step();
    mul_done = 1'b0;
    chk("wait_no_rsp", int'(rsp_valid), 0);
    chk("wait_start_low", int'(mul_start), 0);
    if (lat > 0) begin
      for (int k = 0; k < lat - 1; k++) step();
      mul_product = {4'b0, mul_a} * {4'b0, mul_b};
      mul_done = 1'b1;
      step();
      mul_done = 1'b0;
    end else begin
      n = 0;
      do begin
        step();
        n++;
      end while (!rsp_valid && n < 300);
      chk("timeout_cycles", n, TO + 1);
    end
    chk("rsp_valid", int'(rsp_valid), 1);
    chk("rsp_id", int'(rsp_id), int'(exp_gnt[1]));
    chk("rsp_product", int'(rsp_product), int'(exp_prod));
    chk("rsp_err", int'(rsp_err), int'(exp_err));
    chk("jobs_before", int'(jobs_done), int'(exp_jobs));
    for (int h = 0; h < hold; h++) begin
      if (lat == 0) begin
        mul_product = 8'hA5;
        mul_done = 1'b1;
      end
      step();
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_product", int'(rsp_product), int'(exp_prod));
      chk("hold_err", int'(rsp_err), int'(exp_err));
      chk("hold_req_ready", int'(req_ready), 0);
      chk("hold_no_start", int'(mul_start), 0);
    end
    mul_done = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    exp_jobs = exp_jobs + 8'd1;
    chk("post_rsp_valid", int'(rsp_valid), 0);
    chk("jobs_after", int'(jobs_done), int'(exp_jobs));
    $display("job id=%0d a=%0d b=%0d prod=%0d err=%0d jobs=%0d",
             exp_gnt[1], ea, eb, rsp_product, rsp_err, jobs_done);
  endtask

  // Reference: round-robin by a single "whose turn" bit; product from arithmetic.
  task automatic model_job(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                           input logic [3:0] a1, input logic [3:0] b1, input int lat,
                           input int hold, input bit idone);
    logic [1:0] g;
    logic [7:0] p;
    if (v == 2'b11) g = rr_m ? 2'b10 : 2'b01;
    else g = v;
    rr_m = (g == 2'b01);
    if (lat == 0) p = 8'd0;
    else if (g[1]) p = 8'(int'(a1) * int'(b1));
    else p = 8'(int'(a0) * int'(b0));
    do_job(v, a0, b0, a1, b1, lat, hold, idone, g, p, (lat == 0));
  endtask

  initial begin
    total = 0; bad = 0; exp_jobs = 8'd0; rr_m = 1'b0;
    nsys_rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; mul_done = 1'b0;
    mul_product = 8'd0; req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;

    tbl[0] = '{2'b01, 4'd7, 4'd9, 4'd0, 4'd0, 4, 10, 1'b0, 2'b01, 8'd63, 1'b0};
    tbl[1] = '{2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 2, 0, 1'b1, 2'b10, 8'd225, 1'b0};
    tbl[2] = '{2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 1, 1, 1'b0, 2'b01, 8'd15, 1'b0};
    tbl[3] = '{2'b10, 4'd0, 4'd0, 4'd2, 4'd6, 3, 0, 1'b0, 2'b10, 8'd12, 1'b0};
    tbl[4] = '{2'b10, 4'd0, 4'd0, 4'd4, 4'd4, 5, 2, 1'b1, 2'b10, 8'd16, 1'b0};
    tbl[5] = '{2'b11, 4'd15, 4'd1, 4'd0, 4'd9, 1, 0, 1'b0, 2'b01, 8'd15, 1'b0};
    tbl[6] = '{2'b11, 4'd8, 4'd8, 4'd5, 4'd3, 6, 0, 1'b0, 2'b10, 8'd15, 1'b0};
    tbl[7] = '{2'b01, 4'd6, 4'd6, 4'd1, 4'd1, 0, 3, 1'b0, 2'b01, 8'd0, 1'b1};
    tbl[8] = '{2'b11, 4'd2, 4'd3, 4'd3, 4'd3, 2, 0, 1'b0, 2'b10, 8'd9, 1'b0};

    repeat (3) step();
    chk_idle_outputs("in_reset");
    nsys_rst = 1'b1;
    step();
    chk_idle_outputs("after_reset");
    chk("after_reset_req_ready", int'(req_ready), 0);

    // Stray done while idle must not produce a response.
    mul_product = 8'hFF;
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    step();
    chk_idle_outputs("stray_idle");

    for (int i = 0; i < 9; i++) begin
      do_job(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].lat,
             tbl[i].hold, tbl[i].idone, tbl[i].gnt, tbl[i].prod, tbl[i].err);
    end

    // Reset in the middle of WAIT; the granted-0 job also moves rr to 1.
    req_valid = 2'b01; req0_a = 4'd5; req0_b = 4'd5;
    step();
    req_valid = 2'b00;
    step();
    step();
    nsys_rst = 1'b0;
    #1;
    chk_idle_outputs("reset_wait");
    step();
    nsys_rst = 1'b1;
    exp_jobs = 8'd0;
    rr_m = 1'b0;
    step();
    chk_idle_outputs("reset_wait_rel");

    // Contention straight after reset: 0, then 1, then 0 again.
    model_job(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 3, 0, 1'b0);
    model_job(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 2, 1, 1'b0);
    model_job(2'b11, 4'd3, 4'd5, 4'd15, 4'd15, 1, 0, 1'b0);

    // Enough random jobs to wrap jobs_done past 255.
    for (int i = 0; i < 260; i++) begin
      logic [1:0] v;
      int lat;
      v = 2'($urandom_range(1, 3));
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      model_job(v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                lat, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
